// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line timing.
// Reused by the transmitter side of the serial port.
package uart_pkg;

   localparam int UART_DATA_BITS            = 8;
   localparam int UART_DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud

   // Receiver FSM states; the RX_ prefix keeps the literals clear of the
   // receiver's DATA port name.
   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_STOP      = 3'd3,
      RX_WAIT_HIGH = 3'd4
   } uart_rx_state_t;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
// The reset value is chosen per use so the output starts at the line's idle level.
module sync2 #(
   parameter logic RESET_VALUE = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= RESET_VALUE;
         sync_r <= RESET_VALUE;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver. Samples each bit mid-period, reassembles the byte
// LSB first and offers it on a one-entry valid/ready holding register.
// Framing errors and dropped bytes are signalled as single-cycle pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      RX,
   output logic [UART_DATA_BITS-1:0] DATA,
   output logic                      VALID,
   input  logic                      READY,
   output logic                      FRAME_ERR,
   output logic                      OVERRUN,
   output logic                      BUSY
);

   localparam int TW = $clog2(CLKS_PER_BIT);

   // START waits one extra cycle beyond half a bit so that the start sample
   // lands exactly CLKS_PER_BIT/2 cycles after START is entered; every later
   // sample is a full bit period after the previous one.
   localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2);
   localparam logic [TW-1:0] BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] TIMER_ZERO  = TW'(0);
   localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
   localparam logic [2:0]    LAST_BIT    = 3'(UART_DATA_BITS - 1);

   logic                      rx_s;

   uart_rx_state_t            state_r;
   uart_rx_state_t            state_nxt_s;
   logic [TW-1:0]             timer_r;
   logic [TW-1:0]             timer_nxt_s;
   logic [2:0]                bit_idx_r;
   logic [2:0]                bit_idx_nxt_s;
   logic [UART_DATA_BITS-1:0] shift_r;
   logic [UART_DATA_BITS-1:0] shift_nxt_s;

   logic                      tick_s;
   logic                      stop_ok_s;
   logic                      stop_bad_s;
   logic                      pop_s;
   logic                      load_s;
   logic                      drop_s;

   logic [UART_DATA_BITS-1:0] data_r;
   logic                      valid_r;
   logic                      frame_err_r;
   logic                      overrun_r;
   logic                      busy_r;

   sync2 #(
      .RESET_VALUE (1'b1)
   ) u_rx_sync (
      .clk   (CLK),
      .rst_n (RST_N),
      .d     (RX),
      .q     (rx_s)
   );

   assign tick_s = (timer_r == TIMER_ZERO);

   // Next-state, bit timer, bit index and shift register update.
   always_comb begin
      state_nxt_s   = state_r;
      timer_nxt_s   = timer_r;
      bit_idx_nxt_s = bit_idx_r;
      shift_nxt_s   = shift_r;
      stop_ok_s     = 1'b0;
      stop_bad_s    = 1'b0;

      case (state_r)
         RX_IDLE: begin
            if (!rx_s) begin
               state_nxt_s = RX_START;
               timer_nxt_s = HALF_RELOAD;
            end else begin
               timer_nxt_s = timer_r;
            end
         end

         RX_START: begin
            if (tick_s) begin
               if (!rx_s) begin
                  state_nxt_s   = RX_DATA;
                  timer_nxt_s   = BIT_RELOAD;
                  bit_idx_nxt_s = 3'd0;
               end else begin
                  // Line returned high before mid-bit: a glitch, not a frame.
                  state_nxt_s = RX_IDLE;
               end
            end else begin
               timer_nxt_s = timer_r - TIMER_ONE;
            end
         end

         RX_DATA: begin
            if (tick_s) begin
               shift_nxt_s = {rx_s, shift_r[UART_DATA_BITS-1:1]};
               timer_nxt_s = BIT_RELOAD;
               if (bit_idx_r == LAST_BIT) begin
                  state_nxt_s = RX_STOP;
               end else begin
                  bit_idx_nxt_s = bit_idx_r + 3'd1;
               end
            end else begin
               timer_nxt_s = timer_r - TIMER_ONE;
            end
         end

         RX_STOP: begin
            if (tick_s) begin
               if (rx_s) begin
                  stop_ok_s   = 1'b1;
                  state_nxt_s = RX_IDLE;
               end else begin
                  stop_bad_s  = 1'b1;
                  state_nxt_s = RX_WAIT_HIGH;
               end
            end else begin
               timer_nxt_s = timer_r - TIMER_ONE;
            end
         end

         RX_WAIT_HIGH: begin
            // A held-low line (break) must release before the next start bit.
            if (rx_s) begin
               state_nxt_s = RX_IDLE;
            end else begin
               state_nxt_s = RX_WAIT_HIGH;
            end
         end

         default: begin
            state_nxt_s = RX_IDLE;
            timer_nxt_s = TIMER_ZERO;
         end
      endcase
   end

   // FSM, timer, bit index and shift register state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r   <= RX_IDLE;
         timer_r   <= TIMER_ZERO;
         bit_idx_r <= 3'd0;
         shift_r   <= {UART_DATA_BITS{1'b0}};
      end else begin
         state_r   <= state_nxt_s;
         timer_r   <= timer_nxt_s;
         bit_idx_r <= bit_idx_nxt_s;
         shift_r   <= shift_nxt_s;
      end
   end

   // A byte is accepted when the slot is empty or is being emptied this cycle.
   assign pop_s  = valid_r & READY;
   assign load_s = stop_ok_s & (~valid_r | READY);
   assign drop_s = stop_ok_s & valid_r & ~READY;

   // Holding register, status pulses and busy flag.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         data_r      <= {UART_DATA_BITS{1'b0}};
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         if (load_s) begin
            data_r  <= shift_r;
            valid_r <= 1'b1;
         end else if (pop_s) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
         frame_err_r <= stop_bad_s;
         overrun_r   <= drop_s;
         busy_r      <= (state_nxt_s != RX_IDLE);
      end
   end

   assign DATA      = data_r;
   assign VALID     = valid_r;
   assign FRAME_ERR = frame_err_r;
   assign OVERRUN   = overrun_r;
   assign BUSY      = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT=8 and a 20-unit clock.
// Cycle numbering: cyc counts rising edges; "e" is the edge on which the
// first synchronizer flop captures the start bit, so a good byte appears on
// VALID in cycle e+79 and the stop sample happens in cycle e+78.
module tb_uart_rx;

   localparam int CPB = 8;

   logic       CLK;
   logic       RST_N;
   logic       RX;
   logic       READY;
   logic [7:0] DATA;
   logic       VALID;
   logic       FRAME_ERR;
   logic       OVERRUN;
   logic       BUSY;

   int cyc       = 0;
   int n_cmp     = 0;
   int n_err     = 0;
   int valid_cnt = 0;
   int fe_cnt    = 0;
   int ov_cnt    = 0;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_fe;
      logic       exp_ov;
   } vec_t;

   vec_t vecs[6];

   uart_rx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .RX        (RX),
      .DATA      (DATA),
      .VALID     (VALID),
      .READY     (READY),
      .FRAME_ERR (FRAME_ERR),
      .OVERRUN   (OVERRUN),
      .BUSY      (BUSY)
   );

   initial CLK = 1'b0;
   always #10 CLK = ~CLK;

   // Edge counter; at a falling edge cyc names the current cycle.
   always @(posedge CLK) cyc <= cyc + 1;

   // Event counters for "never asserts" style checks.
   always @(negedge CLK) begin
      if (RST_N) begin
         if (VALID)     valid_cnt <= valid_cnt + 1;
         if (FRAME_ERR) fe_cnt    <= fe_cnt + 1;
         if (OVERRUN)   ov_cnt    <= ov_cnt + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_cycle(input int n);
      while (cyc < n) @(negedge CLK);
   endtask

   // Drives one 8N1 frame starting at the current falling edge.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      RX = 1'b0;
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (CPB) @(negedge CLK);
      end
      RX = stop_bit;
      repeat (CPB) @(negedge CLK);
      RX = 1'b1;
   endtask

   // Sends a good frame with READY=1 and checks the exact output cycle.
   task automatic frame_and_check(input logic [7:0] tx, input logic [7:0] exp_data,
                                  input logic exp_valid, input logic exp_fe,
                                  input logic exp_ov, input string tag);
      int e;
      @(negedge CLK);
      e = cyc + 1;
      fork
         send_frame(tx, 1'b1);
         begin
            wait_cycle(e + 78);
            check({tag, " valid_early"}, 32'(VALID), 32'd0);
            wait_cycle(e + 79);
            check({tag, " data"},  32'(DATA),      32'(exp_data));
            check({tag, " valid"}, 32'(VALID),     32'(exp_valid));
            check({tag, " ferr"},  32'(FRAME_ERR), 32'(exp_fe));
            check({tag, " ovr"},   32'(OVERRUN),   32'(exp_ov));
            wait_cycle(e + 80);
            check({tag, " valid_popped"}, 32'(VALID), 32'd0);
         end
      join
      repeat (4) @(negedge CLK);
   endtask

   initial begin
      int e;
      int e2;
      int base_v;
      int base_fe;
      int base_ov;

      vecs[0] = '{tx: 8'hA5, exp_data: 8'hA5, exp_valid: 1'b1, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[1] = '{tx: 8'h00, exp_data: 8'h00, exp_valid: 1'b1, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[2] = '{tx: 8'hFF, exp_data: 8'hFF, exp_valid: 1'b1, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[3] = '{tx: 8'h01, exp_data: 8'h01, exp_valid: 1'b1, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[4] = '{tx: 8'h80, exp_data: 8'h80, exp_valid: 1'b1, exp_fe: 1'b0, exp_ov: 1'b0};
      vecs[5] = '{tx: 8'h3C, exp_data: 8'h3C, exp_valid: 1'b1, exp_fe: 1'b0, exp_ov: 1'b0};

      RST_N = 1'b0;
      RX    = 1'b1;
      READY = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst data",  32'(DATA),      32'd0);
      check("rst valid", 32'(VALID),     32'd0);
      check("rst ferr",  32'(FRAME_ERR), 32'd0);
      check("rst ovr",   32'(OVERRUN),   32'd0);
      check("rst busy",  32'(BUSY),      32'd0);
      RST_N = 1'b1;
      repeat (4) @(negedge CLK);

      // Table of good frames.
      for (int i = 0; i < 6; i++) begin
         frame_and_check(vecs[i].tx, vecs[i].exp_data, vecs[i].exp_valid,
                         vecs[i].exp_fe, vecs[i].exp_ov, $sformatf("vec%0d", i));
      end

      // Glitch: two cycles low.
      base_v  = valid_cnt;
      base_fe = fe_cnt;
      base_ov = ov_cnt;
      @(negedge CLK);
      e = cyc + 1;
      RX = 1'b0;
      repeat (2) @(negedge CLK);
      RX = 1'b1;
      wait_cycle(e + 3);
      check("glitch busy_start", 32'(BUSY), 32'd1);
      wait_cycle(e + 8);
      check("glitch busy_idle", 32'(BUSY), 32'd0);
      repeat (80) @(negedge CLK);
      check("glitch no_valid", 32'(valid_cnt), 32'(base_v));
      check("glitch no_ferr",  32'(fe_cnt),    32'(base_fe));
      check("glitch no_ovr",   32'(ov_cnt),    32'(base_ov));

      // Framing error followed by a three-bit break.
      base_v  = valid_cnt;
      base_fe = fe_cnt;
      @(negedge CLK);
      e = cyc + 1;
      fork
         begin
            send_frame(8'h3C, 1'b0);
            RX = 1'b0;
            repeat (3 * CPB) @(negedge CLK);
            RX = 1'b1;
         end
         begin
            wait_cycle(e + 78);
            check("ferr early", 32'(FRAME_ERR), 32'd0);
            wait_cycle(e + 79);
            check("ferr pulse", 32'(FRAME_ERR), 32'd1);
            check("ferr valid", 32'(VALID),     32'd0);
            wait_cycle(e + 80);
            check("ferr one_cycle", 32'(FRAME_ERR), 32'd0);
            wait_cycle(e + 95);
            check("ferr wait_high_busy", 32'(BUSY), 32'd1);
         end
      join
      repeat (6) @(negedge CLK);
      check("ferr idle_after", 32'(BUSY),      32'd0);
      check("ferr no_bytes",   32'(valid_cnt), 32'(base_v));
      check("ferr count",      32'(fe_cnt),    32'(base_fe + 1));
      frame_and_check(8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, "after_ferr");

      // Overrun: two back-to-back frames with nobody reading.
      READY   = 1'b0;
      base_ov = ov_cnt;
      @(negedge CLK);
      e  = cyc + 1;
      e2 = e + 80;
      fork
         begin
            send_frame(8'h11, 1'b1);
            send_frame(8'h22, 1'b1);
         end
         begin
            wait_cycle(e + 79);
            check("ovr first_valid", 32'(VALID), 32'd1);
            check("ovr first_data",  32'(DATA),  32'h11);
            wait_cycle(e2 + 78);
            check("ovr early", 32'(OVERRUN), 32'd0);
            wait_cycle(e2 + 79);
            check("ovr pulse", 32'(OVERRUN), 32'd1);
            check("ovr valid", 32'(VALID),   32'd1);
            check("ovr data",  32'(DATA),    32'h11);
            wait_cycle(e2 + 80);
            check("ovr one_cycle", 32'(OVERRUN), 32'd0);
            check("ovr data_kept", 32'(DATA),    32'h11);
         end
      join
      check("ovr count", 32'(ov_cnt), 32'(base_ov + 1));
      READY = 1'b1;
      @(negedge CLK);
      check("ovr popped", 32'(VALID), 32'd0);
      repeat (4) @(negedge CLK);

      // Load and pop in the same stop-sample cycle.
      READY   = 1'b0;
      base_ov = ov_cnt;
      @(negedge CLK);
      e = cyc + 1;
      fork
         send_frame(8'h11, 1'b1);
         begin
            wait_cycle(e + 79);
            check("simul first_data", 32'(DATA), 32'h11);
         end
      join
      repeat (3) @(negedge CLK);
      e2 = cyc + 1;
      fork
         send_frame(8'h22, 1'b1);
         begin
            wait_cycle(e2 + 78);
            READY = 1'b1;
            wait_cycle(e2 + 79);
            check("simul valid", 32'(VALID),   32'd1);
            check("simul data",  32'(DATA),    32'h22);
            check("simul ovr",   32'(OVERRUN), 32'd0);
            READY = 1'b0;
            wait_cycle(e2 + 80);
            check("simul held", 32'(VALID), 32'd1);
         end
      join
      check("simul ovr_count", 32'(ov_cnt), 32'(base_ov));
      READY = 1'b1;
      @(negedge CLK);
      check("simul popped", 32'(VALID), 32'd0);
      repeat (4) @(negedge CLK);

      // Reset in the middle of data bit 4 while a byte is still pending.
      READY = 1'b0;
      @(negedge CLK);
      e = cyc + 1;
      fork
         send_frame(8'h77, 1'b1);
         begin
            wait_cycle(e + 79);
            check("rstmid pending", 32'(VALID), 32'd1);
         end
      join
      repeat (3) @(negedge CLK);
      e = cyc + 1;
      fork
         send_frame(8'hC3, 1'b1);
         begin
            wait_cycle(e + 43);
            check("rstmid busy_before", 32'(BUSY), 32'd1);
            RST_N = 1'b0;
            #1;
            check("rstmid data",  32'(DATA),      32'd0);
            check("rstmid valid", 32'(VALID),     32'd0);
            check("rstmid ferr",  32'(FRAME_ERR), 32'd0);
            check("rstmid ovr",   32'(OVERRUN),   32'd0);
            check("rstmid busy",  32'(BUSY),      32'd0);
         end
      join
      repeat (4) @(negedge CLK);
      RST_N = 1'b1;
      READY = 1'b1;
      repeat (4) @(negedge CLK);
      check("rstmid idle_after", 32'(BUSY),  32'd0);
      check("rstmid empty",      32'(VALID), 32'd0);
      frame_and_check(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
